// File: rtl/vga_fill_ctrl_if.sv
// Core I/O bus bundle between the CPU and the VGA write controller.
// The master drives address/data/strobe; the slave returns combinational read data.
interface vga_fill_ctrl_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        output bus_rdata
    );
endinterface

// File: rtl/vga_fill_ctrl.sv
// Memory-mapped VGA write controller: direct CPU pixel writes plus a
// rectangle-fill engine sharing one registered pixel write port.
module vga_fill_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          DISP_W    = 400,
    parameter int          DISP_H    = 300,
    parameter int          CW        = 9
) (
    input  logic            clk,
    input  logic            rst,
    vga_fill_ctrl_if.slave  bus,
    input  logic            frame_trig,
    output logic            px_we,
    output logic [CW-1:0]   px_x,
    output logic [CW-1:0]   px_y,
    output logic [11:0]     px_colour,
    output logic            busy,
    output logic            done
);
    localparam int EW = CW + 1;
    localparam logic [EW-1:0] DISP_W_E = EW'(DISP_W);
    localparam logic [EW-1:0] DISP_H_E = EW'(DISP_H);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        FILL       = 2'd2
    } state_t;

    state_t          state_q;

    // Programmable registers
    logic [CW-1:0]   x0_q, y0_q, w_q, h_q;
    logic [11:0]     colour_q;
    logic            err_q;
    logic [15:0]     frame_cnt_q;

    // Engine context latched at start
    logic [CW-1:0]   cur_x_q, cur_y_q, xs_q;
    logic [EW-1:0]   xe_q, ye_q;
    logic [11:0]     fcol_q;
    logic            more_q;

    // Registered pixel port
    logic            px_we_q;
    logic [CW-1:0]   px_x_q, px_y_q;
    logic [11:0]     px_col_q;
    logic            done_q;

    // Bus decode
    logic            hit, wr;
    logic [2:0]      sel;
    logic            wr_pixel, wr_ctrl;
    logic            ctrl_start, ctrl_vsync, ctrl_clr;
    logic [8:0]      pix_x9, pix_y9;
    logic [11:0]     pix_c;
    logic            cpu_px;
    logic            start_ok;
    logic [31:0]     rdata_d;
    logic            unused_bits;

    assign hit        = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign sel        = bus.bus_addr[4:2];
    assign wr         = bus.bus_we && hit;
    assign wr_pixel   = wr && (sel == 3'd0);
    assign wr_ctrl    = wr && (sel == 3'd4);
    assign ctrl_start = bus.bus_wdata[0];
    assign ctrl_vsync = bus.bus_wdata[1];
    assign ctrl_clr   = bus.bus_wdata[2];
    assign pix_c      = bus.bus_wdata[11:0];
    assign pix_x9     = bus.bus_wdata[20:12];
    assign pix_y9     = bus.bus_wdata[29:21];
    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata};

    // Off-screen CPU pixels are dropped outright so they never stall the engine
    assign cpu_px   = wr_pixel && (EW'(pix_x9) < DISP_W_E) && (EW'(pix_y9) < DISP_H_E);
    assign start_ok = wr_ctrl && ctrl_start && (state_q == IDLE);

    // Clipped bounds from the live registers, used only at start
    logic [EW-1:0]   sum_x, sum_y, clip_xe, clip_ye;
    logic            rect_empty;

    assign sum_x      = EW'(x0_q) + EW'(w_q);
    assign sum_y      = EW'(y0_q) + EW'(h_q);
    assign clip_xe    = (sum_x > DISP_W_E) ? DISP_W_E : sum_x;
    assign clip_ye    = (sum_y > DISP_H_E) ? DISP_H_E : sum_y;
    assign rect_empty = (w_q == '0) || (h_q == '0) ||
                        (EW'(x0_q) >= DISP_W_E) || (EW'(y0_q) >= DISP_H_E);

    // Pixel the engine would emit this cycle and the raster step after it.
    // In IDLE the first pixel comes straight from the registers so it can
    // reach the port on the cycle after start.
    logic [CW-1:0]   e_x, e_y, e_xs, nx, ny;
    logic [EW-1:0]   e_xe, e_ye, x_inc, y_inc;
    logic [11:0]     e_col;
    logic            n_last;
    logic            eng_go;

    always_comb begin
        e_x   = cur_x_q;
        e_y   = cur_y_q;
        e_xs  = xs_q;
        e_xe  = xe_q;
        e_ye  = ye_q;
        e_col = fcol_q;
        if (state_q == IDLE) begin
            e_x   = x0_q;
            e_y   = y0_q;
            e_xs  = x0_q;
            e_xe  = clip_xe;
            e_ye  = clip_ye;
            e_col = colour_q;
        end
        x_inc = EW'(e_x) + EW'(1);
        y_inc = EW'(e_y) + EW'(1);
        if (x_inc < e_xe) begin
            nx     = CW'(x_inc);
            ny     = e_y;
            n_last = 1'b0;
        end else begin
            nx     = e_xs;
            ny     = CW'(y_inc);
            n_last = (y_inc >= e_ye);
        end
    end

    assign eng_go = ((state_q == FILL) && more_q) ||
                    ((state_q == WAIT_FRAME) && frame_trig) ||
                    (start_ok && !ctrl_vsync && !rect_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            colour_q    <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            xs_q        <= '0;
            xe_q        <= '0;
            ye_q        <= '0;
            fcol_q      <= '0;
            more_q      <= 1'b0;
            px_we_q     <= 1'b0;
            px_x_q      <= '0;
            px_y_q      <= '0;
            px_col_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            px_we_q <= 1'b0;

            if (frame_trig)
                frame_cnt_q <= frame_cnt_q + 16'd1;

            if (wr) begin
                case (sel)
                    3'd1: begin
                        x0_q <= bus.bus_wdata[CW-1:0];
                        y0_q <= bus.bus_wdata[16 +: CW];
                    end
                    3'd2: begin
                        w_q <= bus.bus_wdata[CW-1:0];
                        h_q <= bus.bus_wdata[16 +: CW];
                    end
                    3'd3: colour_q <= bus.bus_wdata[11:0];
                    default: ;
                endcase
            end

            // Clear is applied before the busy check so clear+start while busy re-flags
            if (wr_ctrl) begin
                if (ctrl_clr)
                    err_q <= 1'b0;
                if (ctrl_start && (state_q != IDLE))
                    err_q <= 1'b1;
            end

            if (cpu_px) begin
                px_we_q  <= 1'b1;
                px_x_q   <= CW'(pix_x9);
                px_y_q   <= CW'(pix_y9);
                px_col_q <= pix_c;
            end else if (eng_go) begin
                px_we_q  <= 1'b1;
                px_x_q   <= e_x;
                px_y_q   <= e_y;
                px_col_q <= e_col;
            end

            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (rect_empty) begin
                            done_q <= 1'b1;
                        end else begin
                            xs_q   <= x0_q;
                            xe_q   <= clip_xe;
                            ye_q   <= clip_ye;
                            fcol_q <= colour_q;
                            if (ctrl_vsync) begin
                                state_q <= WAIT_FRAME;
                                cur_x_q <= x0_q;
                                cur_y_q <= y0_q;
                                more_q  <= 1'b1;
                            end else begin
                                state_q <= FILL;
                                cur_x_q <= nx;
                                cur_y_q <= ny;
                                more_q  <= !n_last;
                            end
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (frame_trig) begin
                        state_q <= FILL;
                        if (!cpu_px) begin
                            cur_x_q <= nx;
                            cur_y_q <= ny;
                            more_q  <= !n_last;
                        end
                    end
                end
                FILL: begin
                    if (!more_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (!cpu_px) begin
                        cur_x_q <= nx;
                        cur_y_q <= ny;
                        more_q  <= !n_last;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (sel)
                3'd1: begin
                    rdata_d[CW-1:0]  = x0_q;
                    rdata_d[16 +: CW] = y0_q;
                end
                3'd2: begin
                    rdata_d[CW-1:0]  = w_q;
                    rdata_d[16 +: CW] = h_q;
                end
                3'd3: rdata_d[11:0] = colour_q;
                3'd5: rdata_d = {frame_cnt_q, 13'd0, err_q,
                                 (state_q == WAIT_FRAME), (state_q != IDLE)};
                default: ;
            endcase
        end
    end

    assign bus.bus_rdata = rdata_d;
    assign px_we     = px_we_q;
    assign px_x      = px_x_q;
    assign px_y      = px_y_q;
    assign px_colour = px_col_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
endmodule
